// File: rtl/operand_sel_pipe.sv
// operand_sel_pipe
// Registered NSRC-input operand selector for the execute-stage forwarding path.
// A DEPTH-stage valid/data/error pipeline sits behind the selector. Every stage
// obeys one priority per cycle: flush kills all valids, otherwise stall holds
// everything, otherwise the pipe advances. Out-of-range selects produce zero
// data with an error flag, and a saturating counter tallies them.
module operand_sel_pipe #(
  parameter int N     = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2,
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic [SELW-1:0]   sel,
  input  logic [NSRC*N-1:0] src,
  output logic [N-1:0]      out_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  // One extra bit so that NSRC == 2^SELW still fits in the comparison.
  localparam logic [SELW:0] NSRC_L = (SELW+1)'(NSRC);

  logic [N-1:0]            sel_data_s;
  logic                    sel_err_s;
  logic                    advance_s;
  logic                    accept_s;

  logic [DEPTH-1:0]        v_q, v_d;
  logic [DEPTH-1:0]        e_q, e_d;
  logic [DEPTH-1:0][N-1:0] d_q, d_d;
  logic [7:0]              cnt_q, cnt_d;

  // A beat enters the pipe only on a cycle with no flush and no stall.
  assign advance_s = !flush && !stall;
  assign accept_s  = in_valid && advance_s;

  // Stage-1 operand: an AND-OR mux over the in-range sources.
  // An out-of-range select matches no source, so the data is zero and the beat is flagged.
  always_comb begin
    sel_data_s = '0;
    sel_err_s  = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      sel_data_s = sel_data_s |
                   ({N{({1'b0, sel} == (SELW+1)'(k))}} & src[k*N +: N]);
    end
    if ({1'b0, sel} < NSRC_L) begin
      sel_err_s = 1'b0;
    end else begin
      sel_err_s = 1'b1;
    end
  end

  // Pipeline next state: flush clears the valids, stall holds, advance shifts.
  // Data and error bits only load behind a valid beat, so bubbles leave them unchanged.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    e_d = e_q;
    if (flush) begin
      v_d = '0;
    end else if (stall) begin
      v_d = v_q;
    end else begin
      v_d[0] = in_valid;
      if (in_valid) begin
        d_d[0] = sel_data_s;
        e_d[0] = sel_err_s;
      end else begin
        d_d[0] = d_q[0];
        e_d[0] = e_q[0];
      end
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          d_d[i] = d_q[i-1];
          e_d[i] = e_q[i-1];
        end else begin
          d_d[i] = d_q[i];
          e_d[i] = e_q[i];
        end
      end
    end
  end

  // The error counter steps when an out-of-range beat is accepted and sticks at 255.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_s && sel_err_s && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers. Reset is asynchronous, so the outputs clear as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      d_q   <= '0;
      e_q   <= '0;
      cnt_q <= 8'd0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  // in_ready depends only on stall. Every out_* is a plain register output.
  assign in_ready  = !stall;
  assign out_data  = d_q[DEPTH-1];
  assign out_valid = v_q[DEPTH-1];
  assign out_err   = e_q[DEPTH-1];
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// tb_operand_sel_pipe
// Scoreboard bench. The driver pushes each accepted beat, together with the
// advance-edge index at which it must surface, into a queue. A negedge monitor
// pops entries from that queue and compares them with the DUT outputs.
module tb_operand_sel_pipe;

  localparam int N     = 32;
  localparam int NSRC  = 3;
  localparam int SELW  = 2;
  localparam int DEPTH = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              stall;
  logic              flush;
  logic [SELW-1:0]   sel;
  logic [NSRC*N-1:0] src;
  logic [N-1:0]      out_data;
  logic              out_valid;
  logic              out_err;
  logic [7:0]        err_cnt;

  operand_sel_pipe #(.N(N), .NSRC(NSRC), .SELW(SELW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .sel(sel), .src(src),
    .out_data(out_data), .out_valid(out_valid), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] data;
    logic         err;
    int unsigned  emerge;
  } beat_t;

  typedef enum {E_NONE, E_ADV, E_STALL, E_FLUSH} edge_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int unsigned  adv_cnt = 0;
  int           model_err_cnt = 0;
  logic [N-1:0] last_data = '0;
  logic         last_err = 1'b0;
  edge_t        last_edge = E_NONE;
  logic [N-1:0] prev_data = '0;
  logic         prev_valid = 1'b0;
  logic         prev_err = 1'b0;
  bit           mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference selection: view the source bus as an array of words and index it.
  function automatic void ref_sel(input logic [SELW-1:0] s, input logic [NSRC*N-1:0] v,
                                  output logic [N-1:0] d, output logic e);
    logic [N-1:0] words [NSRC];
    for (int k = 0; k < NSRC; k++) words[k] = v[k*N +: N];
    if (int'(s) >= NSRC) begin
      d = '0;
      e = 1'b1;
    end else begin
      d = words[int'(s)];
      e = 1'b0;
    end
  endfunction

  // Drive one cycle, then update the reference model for the edge that follows.
  task automatic cycle(input logic iv, input logic st, input logic fl,
                       input logic [SELW-1:0] s, input logic [NSRC*N-1:0] v);
    logic [N-1:0] d;
    logic         e;
    in_valid = iv; stall = st; flush = fl; sel = s; src = v;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      last_edge = E_FLUSH;
    end else if (st) begin
      last_edge = E_STALL;
    end else begin
      adv_cnt++;
      if (iv) begin
        ref_sel(s, v, d, e);
        exp_q.push_back('{data: d, err: e, emerge: adv_cnt + DEPTH - 1});
        if (e && model_err_cnt < 255) model_err_cnt++;
      end
      last_edge = E_ADV;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, '0);
  endtask

  function automatic logic [NSRC*N-1:0] rnd_src();
    logic [NSRC*N-1:0] r;
    for (int k = 0; k < NSRC; k++) r[k*N +: N] = $urandom;
    return r;
  endfunction

  // Assert reset between clock edges and check that the outputs clear at once.
  task automatic async_reset();
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    stall = 1'b1; #1 chk("rst_in_ready_stall", in_ready, 1'b0);
    stall = 1'b0; #1 chk("rst_in_ready_nostall", in_ready, 1'b1);
    in_valid = 1'b1; flush = 1'b0; sel = 2'd0;
    @(posedge clk); #1;
    chk("rst_hold_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    exp_q.delete();
    model_err_cnt = 0; last_data = '0; last_err = 1'b0; adv_cnt = 0;
    prev_data = '0; prev_valid = 1'b0; prev_err = 1'b0; last_edge = E_NONE;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: after each edge, compare the outputs with what the model predicts for that edge kind.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        chk("in_ready", in_ready, !stall);
        chk("err_cnt", err_cnt, model_err_cnt[7:0]);
        case (last_edge)
          E_FLUSH: begin
            chk("flush_valid", out_valid, 1'b0);
            chk("flush_data", out_data, last_data);
            chk("flush_err", out_err, last_err);
          end
          E_STALL: begin
            chk("stall_valid", out_valid, prev_valid);
            chk("stall_data", out_data, prev_data);
            chk("stall_err", out_err, prev_err);
          end
          E_ADV: begin
            if (exp_q.size() > 0 && exp_q[0].emerge == adv_cnt) begin
              b = exp_q.pop_front();
              chk("beat_valid", out_valid, 1'b1);
              chk("beat_data", out_data, b.data);
              chk("beat_err", out_err, b.err);
              last_data = b.data;
              last_err  = b.err;
            end else begin
              chk("bubble_valid", out_valid, 1'b0);
              chk("bubble_data", out_data, last_data);
              chk("bubble_err", out_err, last_err);
            end
          end
          default: ;
        endcase
        prev_valid = out_valid;
        prev_data  = out_data;
        prev_err   = out_err;
      end
    end
  end

  initial begin
    logic [NSRC*N-1:0] sweep_src;
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; sel = '0; src = '0;
    #1;
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_out_data", out_data, 32'h0);
    chk("init_err_cnt", err_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Select sweep, including one out-of-range select.
    sweep_src = {32'h33333333, 32'h22222222, 32'h11111111};
    for (int s = 0; s < 4; s++) cycle(1'b1, 1'b0, 1'b0, SELW'(s), sweep_src);
    idle(4);
    chk("sweep_err_cnt", err_cnt, 8'd1);

    // Stall for two cycles after B, with beats A B C D.
    cycle(1'b1, 1'b0, 1'b0, 2'd0, {32'h0, 32'h0, 32'hAAAA0001});
    cycle(1'b1, 1'b0, 1'b0, 2'd1, {32'h0, 32'hBBBB0002, 32'h0});
    cycle(1'b1, 1'b1, 1'b0, 2'd2, {32'h99999999, 32'h0, 32'h0});
    cycle(1'b1, 1'b1, 1'b0, 2'd2, {32'h99999999, 32'h0, 32'h0});
    cycle(1'b1, 1'b0, 1'b0, 2'd2, {32'hCCCC0003, 32'h0, 32'h0});
    cycle(1'b1, 1'b0, 1'b0, 2'd0, {32'h0, 32'h0, 32'hDDDD0004});
    idle(4);

    // Fill the pipe, then offer an invalid-select beat under flush and stall together.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, SELW'(i), rnd_src());
    cycle(1'b1, 1'b1, 1'b1, 2'd3, rnd_src());
    idle(3);
    chk("flush_err_cnt_kept", err_cnt, 8'd1);

    // Bubble retention.
    cycle(1'b1, 1'b0, 1'b0, 2'd1, {32'h0, 32'hDEADBEEF, 32'h0});
    idle(6);
    chk("bubble_keep_data", out_data, 32'hDEADBEEF);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 5), SELW'($urandom_range(0, 3)), rnd_src());
    end
    idle(5);
    chk("drain_empty", exp_q.size(), 0);

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 1'b0, 2'd3, rnd_src());
    idle(4);
    chk("sat_err_cnt", err_cnt, 8'd255);

    // Reset mid-stream while a live beat is on the output.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, SELW'(i % 3), rnd_src());
    chk("pre_rst_valid", out_valid, 1'b1);
    async_reset();

    // Traffic right after reset release.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, SELW'(i % 4), rnd_src());
    idle(4);
    chk("post_rst_drain", exp_q.size(), 0);
    chk("post_rst_err_cnt", err_cnt, 8'd1);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_sel_pipe.md
# operand_sel_pipe

Parametrised, registered N-input operand selector for the execute-stage forwarding path. It generalises the plain combinational 3-of-4 select to NSRC sources of width N, with a DEPTH-stage register pipeline. Each stage supports stall (hold) and flush (kill). Out-of-range selects resolve deterministically and are flagged and counted. It sits between the forwarding control and the ALU operand inputs, aligned to the processor's stall/flush signals.

## Interface
- N, 32: data width per source.
- NSRC, 4: number of sources, 2..16.
- SELW, 2: select width; must satisfy 2^SELW >= NSRC.
- DEPTH, 1: register stages, 1..4.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat present on sel/src.
- in_ready  output  1  equals !stall; a beat is accepted when in_valid && in_ready && !flush.
- stall  input  1  freeze all stages.
- flush  input  1  kill every in-flight beat and any beat offered this cycle.
- sel  input  SELW  source index.
- src  input  NSRC*N  flattened sources; source k occupies bits [k*N +: N].
- out_data  output  N  selected data from the last stage.
- out_valid  output  1  out_data holds a live beat.
- out_err  output  1  the live beat had sel >= NSRC.
- err_cnt  output  8  saturating count of accepted out-of-range beats.

## Operation
- Each stage i (1..DEPTH) holds v[i], d[i] and e[i]. Outputs are v/d/e of stage DEPTH.
- Stage 1 input:
  - In range: d = src[sel*N +: N], e = 0.
  - sel >= NSRC: d = 0, e = 1. There is never a latch or an undefined output.
- Priority per cycle is flush, then stall, then advance.
- Flush: all v[i] cleared at the edge. d/e retained. The offered beat is dropped and not counted. Flush overrides a simultaneous stall.
- Stall (without flush): every v/d/e register holds. in_ready = 0. The offered beat is not accepted.
- Advance (neither flush nor stall):
  - v[1] = in_valid and v[i] = v[i-1].
  - d/e of a stage load only when the incoming valid is 1; otherwise d/e retain their old value (bubbles do not toggle data).
- err_cnt increments by 1 on each accepted beat with sel >= NSRC. It saturates at 255 and clears only on rst.
- Reset (async, mid-operation included): all v, d, e = 0 and err_cnt = 0 immediately on assertion. Outputs are out_valid=0, out_data=0, out_err=0, err_cnt=0 and in_ready = !stall. The first acceptance can occur on the first rising edge after rst deasserts.

## Timing
- Latency is exactly DEPTH accepted-advance cycles: a beat accepted at edge t appears at out_* after edge t+DEPTH-1 (DEPTH=1: visible right after edge t), plus one extra edge per stalled cycle in between.
- Throughput is one beat per cycle when stall=0. There are no internal bubbles.
- in_ready is combinational from stall only; there is no path from sel/src/in_valid to in_ready.
- out_* are pure register outputs; there is no combinational path from inputs.
- Stall for K cycles holds out_* constant for K cycles, with no duplicated or lost beats.
- Flush asserted at edge t: out_valid = 0 after edge t. Beats accepted from edge t+1 onward flow normally.
- Simultaneous stall and flush: treated as flush.
- err_cnt updates at the accepting edge, not at output time.

## Test plan
- Reset/defaults: assert rst mid-stream with out_valid=1 → out_valid, out_data, out_err and err_cnt read 0 immediately. in_ready follows stall.
- Select sweep, N=32, NSRC=4, DEPTH=2: src = {0x44444444, 0x33333333, 0x22222222, 0x11111111}, sel 0..3 on consecutive cycles → out_data 0x11111111, 0x22222222, 0x33333333, 0x44444444 after edges t+1..t+4, out_err=0 throughout.
- Invalid select, NSRC=3, SELW=2: sel=3 → out_data=0 and out_err=1 after the latency, err_cnt=1. Drive 300 such beats → err_cnt saturates and stays at 255.
- Stall: DEPTH=3, stream beats A, B, C, D, then stall for 2 cycles after B is accepted → in_ready=0 and out_* frozen for 2 cycles. Output order is exactly A, B, C, D with no duplicates.
- Flush with stall: DEPTH=3 pipe full, assert flush and stall together with in_valid=1 → out_valid=0 for the next 3 edges. The offered beat never appears and err_cnt is unchanged even if its sel was invalid.
- Bubble retention: in_valid=0 for 4 cycles after beat 0xDEADBEEF → out_valid=0 and out_data stays 0xDEADBEEF.
